// File: rtl/memory_bus_pkg.sv
// Shared types and widths for the memory_bus protocol and its responder.
package memory_bus_pkg;

  localparam int WORD_WIDTH     = 16;
  localparam int BUS_ADDR_WIDTH = 16;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } read_tag_t;

endpackage

// File: rtl/memory_bus.sv
// memory_bus signal bundle; the cpu drives the master side, memories implement the slave side.
interface memory_bus;

  logic                                valid;
  logic                                write;
  logic [memory_bus_pkg::BUS_ADDR_WIDTH-1:0] address;
  logic [memory_bus_pkg::WORD_WIDTH-1:0]     write_data;
  logic                                ready;
  logic [memory_bus_pkg::WORD_WIDTH-1:0]     read_data;
  logic                                read_valid;

  modport master (
    output valid, write, address, write_data,
    input  ready, read_data, read_valid
  );

  modport slave (
    input  valid, write, address, write_data,
    output ready, read_data, read_valid
  );

endinterface

// File: rtl/memory_bus_arbiter.sv
// One-hot grant between the inst and data ports of the shared RAM.
// MEMORY_BUS_ROUND_ROBIN_EN: alternate grants on contention instead of data-over-inst priority.
module memory_bus_arbiter
  import memory_bus_pkg::*;
(
`ifdef MEMORY_BUS_ROUND_ROBIN_EN
  input  logic clock,
  input  logic reset,
`endif
  input  logic i_instValid,
  input  logic i_dataValid,
  output logic o_instGrant,
  output logic o_dataGrant
);

  port_id_t w_winner;

`ifdef MEMORY_BUS_ROUND_ROBIN_EN
  port_id_t r_lastGrant;

  // Only contended cycles move the pointer, so uncontended traffic never skews fairness.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lastGrant <= PORT_INST;
    end else if (i_instValid && i_dataValid) begin
      r_lastGrant <= w_winner;
    end
  end

  assign w_winner = (r_lastGrant == PORT_INST) ? PORT_DATA : PORT_INST;
`else
  assign w_winner = PORT_DATA;
`endif

  // An idle port sees the grant it would get, which with both idle is the contention winner.
  always_comb begin
    o_instGrant = 1'b0;
    o_dataGrant = 1'b0;
    if (i_dataValid && !i_instValid) begin
      o_dataGrant = 1'b1;
    end else if (i_instValid && !i_dataValid) begin
      o_instGrant = 1'b1;
    end else if (w_winner == PORT_DATA) begin
      o_dataGrant = 1'b1;
    end else begin
      o_instGrant = 1'b1;
    end
  end

endmodule

// File: rtl/memory_bus_responder.sv
// Dual-port memory_bus responder over one single-port word RAM with fixed-latency reads.
// MEMORY_BUS_ROUND_ROBIN_EN selects round-robin arbitration (default: data over inst).
module memory_bus_responder
  import memory_bus_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input logic      clock,
  input logic      reset,
  memory_bus.slave inst,
  memory_bus.slave data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_instGrant;
  logic                  w_dataGrant;
  logic                  w_instAccept;
  logic                  w_dataAccept;
  logic                  w_accept;
  logic                  w_write;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WORD_WIDTH-1:0] w_writeData;
  logic [WORD_WIDTH-1:0] w_readWord;
  logic [WORD_WIDTH-1:0] w_finalData;
  read_tag_t             w_newTag;
  read_tag_t             w_finalTag;

  logic                  r_instReadValid;
  logic                  r_dataReadValid;
  logic [WORD_WIDTH-1:0] r_instReadData;
  logic [WORD_WIDTH-1:0] r_dataReadData;

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_badLatency
      $error("memory_bus_responder: LATENCY must be within 1..4");
    end
  endgenerate

  generate
    if (ADDR_WIDTH < BUS_ADDR_WIDTH) begin : g_unusedAddr
      logic w_unusedAddrBits;
      assign w_unusedAddrBits = ^{inst.address[BUS_ADDR_WIDTH-1:ADDR_WIDTH],
                                  data.address[BUS_ADDR_WIDTH-1:ADDR_WIDTH]};
    end
  endgenerate

  memory_bus_arbiter u_arbiter (
`ifdef MEMORY_BUS_ROUND_ROBIN_EN
    .clock       (clock),
    .reset       (reset),
`endif
    .i_instValid (inst.valid),
    .i_dataValid (data.valid),
    .o_instGrant (w_instGrant),
    .o_dataGrant (w_dataGrant)
  );

  assign inst.ready   = w_instGrant && !reset;
  assign data.ready   = w_dataGrant && !reset;
  assign w_instAccept = inst.valid && inst.ready;
  assign w_dataAccept = data.valid && data.ready;
  assign w_accept     = w_instAccept || w_dataAccept;

  // The grants are one-hot, so the data port is selected only when it actually won.
  always_comb begin
    if (w_dataAccept) begin
      w_addr        = data.address[ADDR_WIDTH-1:0];
      w_write       = data.write;
      w_writeData   = data.write_data;
      w_newTag.port = PORT_DATA;
    end else begin
      w_addr        = inst.address[ADDR_WIDTH-1:0];
      w_write       = inst.write;
      w_writeData   = inst.write_data;
      w_newTag.port = PORT_INST;
    end
    w_newTag.valid = w_accept && !w_write;
  end

  always_ff @(posedge clock) begin
    if (w_accept && w_write) begin
      r_mem[w_addr] <= w_writeData;
    end
  end

  assign w_readWord = r_mem[w_addr];

  // Read data is captured at accept; the port output register forms the last stage.
  generate
    if (LATENCY == 1) begin : g_noPipe
      assign w_finalTag  = w_newTag;
      assign w_finalData = w_readWord;
    end else begin : g_pipe
      read_tag_t             r_tag  [LATENCY-1];
      logic [WORD_WIDTH-1:0] r_data [LATENCY-1];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            r_tag[i]  <= '{valid: 1'b0, port: PORT_INST};
            r_data[i] <= '0;
          end
        end else begin
          r_tag[0]  <= w_newTag;
          r_data[0] <= w_readWord;
          for (int i = 1; i < LATENCY - 1; i++) begin
            r_tag[i]  <= r_tag[i-1];
            r_data[i] <= r_data[i-1];
          end
        end
      end

      assign w_finalTag  = r_tag[LATENCY-2];
      assign w_finalData = r_data[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instReadValid <= 1'b0;
      r_dataReadValid <= 1'b0;
      r_instReadData  <= '0;
      r_dataReadData  <= '0;
    end else begin
      r_instReadValid <= w_finalTag.valid && (w_finalTag.port == PORT_INST);
      r_dataReadValid <= w_finalTag.valid && (w_finalTag.port == PORT_DATA);
      if (w_finalTag.valid && (w_finalTag.port == PORT_INST)) begin
        r_instReadData <= w_finalData;
      end
      if (w_finalTag.valid && (w_finalTag.port == PORT_DATA)) begin
        r_dataReadData <= w_finalData;
      end
    end
  end

  assign inst.read_valid = r_instReadValid;
  assign inst.read_data  = r_instReadData;
  assign data.read_valid = r_dataReadValid;
  assign data.read_data  = r_dataReadData;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Self-checking bench for memory_bus_responder: directed vector table, contention and
// reset sequences, then randomized traffic checked against a cycle-indexed reference model.
module tb_memory_bus_responder;

  localparam int LAT = 3;

  typedef struct {
    logic        iv;
    logic        iw;
    logic [15:0] ia;
    logic [15:0] iwd;
    logic        dv;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dwd;
    logic        eIr;
    logic        eDr;
    logic        eIv;
    logic [15:0] eId;
    logic        eDv;
    logic [15:0] eDd;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Expected responses, indexed by (cycle mod 8) and port (0 = inst, 1 = data).
  bit          expRv [8][2];
  logic [15:0] expRd [8][2];
  bit          expKn [8][2];
  logic [15:0] lastRd [2];
  bit          lastKn [2];
  logic [15:0] memModel [int];
`ifdef MEMORY_BUS_ROUND_ROBIN_EN
  bit          lastWasData;
`endif

  memory_bus instBus ();
  memory_bus dataBus ();

  memory_bus_responder #(
    .ADDR_WIDTH (12),
    .LATENCY    (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clock (clock),
    .reset (reset),
    .inst  (instBus),
    .data  (dataBus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic modelAccess(input int p, input logic w, input logic [15:0] a,
                             input logic [15:0] wd, input int sched);
    int key;
    key = int'(a[11:0]);
    if (w) begin
      memModel[key] = wd;
    end else begin
      expRv[sched][p] = 1'b1;
      expKn[sched][p] = (memModel.exists(key) != 0);
      expRd[sched][p] = expKn[sched][p] ? memModel[key] : 16'h0000;
    end
  endtask

  // Drives one cycle of inputs, then at the falling edge checks the DUT against the model.
  task automatic applyStimulus(input logic rst,
                               input logic iv, input logic iw, input logic [15:0] ia, input logic [15:0] iwd,
                               input logic dv, input logic dw, input logic [15:0] da, input logic [15:0] dwd,
                               output logic accI, output logic accD);
    logic        eI;
    logic        eD;
    int          slot;
    int          sched;
    logic        actRv [2];
    logic [15:0] actRd [2];
    reset              = rst;
    instBus.valid      = iv;
    instBus.write      = iw;
    instBus.address    = ia;
    instBus.write_data = iwd;
    dataBus.valid      = dv;
    dataBus.write      = dw;
    dataBus.address    = da;
    dataBus.write_data = dwd;
    @(negedge clock);
    slot = cyc % 8;
    if (rst) begin
      for (int s = 0; s < 8; s++) begin
        for (int p = 0; p < 2; p++) begin
          expRv[s][p] = 1'b0;
          expKn[s][p] = 1'b0;
          expRd[s][p] = 16'h0000;
        end
      end
      lastRd[0] = 16'h0000;
      lastRd[1] = 16'h0000;
      lastKn[0] = 1'b1;
      lastKn[1] = 1'b1;
`ifdef MEMORY_BUS_ROUND_ROBIN_EN
      lastWasData = 1'b0;
`endif
    end
    if (rst) begin
      eI = 1'b0;
      eD = 1'b0;
    end else if (iv && dv) begin
`ifdef MEMORY_BUS_ROUND_ROBIN_EN
      eD = !lastWasData;
`else
      eD = 1'b1;
`endif
      eI = !eD;
    end else begin
      eI = iv;
      eD = dv;
    end
    if (iv) checkOutput("inst_ready", {15'b0, instBus.ready}, {15'b0, eI});
    if (dv) checkOutput("data_ready", {15'b0, dataBus.ready}, {15'b0, eD});
    checkOutput("ready_one_hot", {15'b0, instBus.ready && dataBus.ready}, 16'h0000);
    actRv[0] = instBus.read_valid;
    actRv[1] = dataBus.read_valid;
    actRd[0] = instBus.read_data;
    actRd[1] = dataBus.read_data;
    for (int p = 0; p < 2; p++) begin
      checkOutput(p == 0 ? "inst_read_valid" : "data_read_valid", {15'b0, actRv[p]}, {15'b0, expRv[slot][p]});
      if (expRv[slot][p]) begin
        if (expKn[slot][p]) checkOutput(p == 0 ? "inst_read_data" : "data_read_data", actRd[p], expRd[slot][p]);
        lastRd[p] = expRd[slot][p];
        lastKn[p] = expKn[slot][p];
      end else if (lastKn[p]) begin
        checkOutput(p == 0 ? "inst_read_data_hold" : "data_read_data_hold", actRd[p], lastRd[p]);
      end
      expRv[slot][p] = 1'b0;
    end
    accI = iv && eI;
    accD = dv && eD;
`ifdef MEMORY_BUS_ROUND_ROBIN_EN
    if (iv && dv && !rst) lastWasData = eD;
`endif
    sched = (cyc + LAT) % 8;
    if (accI) modelAccess(0, iw, ia, iwd, sched);
    if (accD) modelAccess(1, dw, da, dwd, sched);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idleCycle();
    logic a;
    logic b;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, a, b);
  endtask

  initial begin
    vec_t        tbl [12];
    logic        accI;
    logic        accD;
    logic        expD;
    logic        pI;
    logic        wI;
    logic [15:0] aI;
    logic [15:0] dI;
    logic        pD;
    logic        wD;
    logic [15:0] aD;
    logic [15:0] dD;
    logic [11:0] addrSet [4];

    addrSet[0] = 12'h200;
    addrSet[1] = 12'h005;
    addrSet[2] = 12'h010;
    addrSet[3] = 12'h0FF;

    //          iv iw ia        iwd       dv dw da        dwd       eIr eDr eIv eId       eDv eDd
    tbl[0]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0200, 16'h1234, 0,  1,  0,  16'h0000, 0,  16'h0000};
    tbl[1]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0,  1,  0,  16'h0000, 0,  16'h0000};
    tbl[2]  = '{1, 1, 16'hF005, 16'hAAAA, 0, 0, 16'h0000, 16'h0000, 1,  0,  0,  16'h0000, 0,  16'h0000};
    tbl[3]  = '{1, 0, 16'h0005, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1,  0,  0,  16'h0000, 0,  16'h0000};
    tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0,  0,  16'h0000, 1,  16'h1234};
    tbl[5]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0010, 16'hBEEF, 0,  1,  0,  16'h0000, 0,  16'h1234};
    tbl[6]  = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1,  0,  1,  16'hAAAA, 0,  16'h1234};
    tbl[7]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h1005, 16'h0000, 0,  1,  0,  16'hAAAA, 0,  16'h1234};
    tbl[8]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0,  0,  16'hAAAA, 0,  16'h1234};
    tbl[9]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0,  1,  16'hBEEF, 0,  16'h1234};
    tbl[10] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0,  0,  16'hBEEF, 1,  16'hAAAA};
    tbl[11] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0,  0,  16'hBEEF, 0,  16'hAAAA};

    @(posedge clock);
    #1;

    // Reset with both ports requesting: nothing may be accepted.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0, accI, accD);
      checkOutput("reset_read_data_inst", instBus.read_data, 16'h0000);
      checkOutput("reset_read_valid_data", {15'b0, dataBus.read_valid}, 16'h0000);
      nextCycle();
    end

    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, tbl[k].iv, tbl[k].iw, tbl[k].ia, tbl[k].iwd,
                    tbl[k].dv, tbl[k].dw, tbl[k].da, tbl[k].dwd, accI, accD);
      if (tbl[k].iv) checkOutput("tbl_inst_ready", {15'b0, instBus.ready}, {15'b0, tbl[k].eIr});
      if (tbl[k].dv) checkOutput("tbl_data_ready", {15'b0, dataBus.ready}, {15'b0, tbl[k].eDr});
      checkOutput("tbl_inst_read_valid", {15'b0, instBus.read_valid}, {15'b0, tbl[k].eIv});
      checkOutput("tbl_inst_read_data", instBus.read_data, tbl[k].eId);
      checkOutput("tbl_data_read_valid", {15'b0, dataBus.read_valid}, {15'b0, tbl[k].eDv});
      checkOutput("tbl_data_read_data", dataBus.read_data, tbl[k].eDd);
      nextCycle();
    end

    // Both ports read continuously for four cycles.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0, accI, accD);
`ifdef MEMORY_BUS_ROUND_ROBIN_EN
      expD = (k % 2 == 0);
`else
      expD = 1'b1;
`endif
      checkOutput("cont_data_ready", {15'b0, dataBus.ready}, {15'b0, expD});
      checkOutput("cont_inst_ready", {15'b0, instBus.ready}, {15'b0, !expD});
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, accI, accD);
    checkOutput("cont_release_inst_ready", {15'b0, instBus.ready}, 16'h0001);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      idleCycle();
      nextCycle();
    end

    // A read in flight is discarded by a one-cycle reset two cycles after accept.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, accI, accD);
    checkOutput("flight_inst_ready", {15'b0, instBus.ready}, 16'h0001);
    nextCycle();
    idleCycle();
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h5555, accI, accD);
    checkOutput("flight_reset_inst_ready", {15'b0, instBus.ready}, 16'h0000);
    checkOutput("flight_reset_data_ready", {15'b0, dataBus.ready}, 16'h0000);
    nextCycle();
    for (int k = 0; k < 6; k++) begin
      idleCycle();
      checkOutput("flight_inst_read_valid", {15'b0, instBus.read_valid}, 16'h0000);
      checkOutput("flight_data_read_valid", {15'b0, dataBus.read_valid}, 16'h0000);
      checkOutput("flight_inst_read_data", instBus.read_data, 16'h0000);
      checkOutput("flight_data_read_data", dataBus.read_data, 16'h0000);
      nextCycle();
    end

    // Random traffic; a pending request is held unchanged until the model says it was accepted.
    pI = 1'b0;
    pD = 1'b0;
    wI = 1'b0;
    wD = 1'b0;
    aI = 16'h0;
    aD = 16'h0;
    dI = 16'h0;
    dD = 16'h0;
    for (int n = 0; n < 400; n++) begin
      if (!pI) begin
        pI = ($urandom_range(0, 1) == 1);
        wI = ($urandom_range(0, 3) == 0);
        aI = {4'($urandom_range(0, 15)), addrSet[$urandom_range(0, 3)]};
        dI = 16'($urandom);
      end
      if (!pD) begin
        pD = ($urandom_range(0, 1) == 1);
        wD = ($urandom_range(0, 2) == 0);
        aD = {4'($urandom_range(0, 15)), addrSet[$urandom_range(0, 3)]};
        dD = 16'($urandom);
      end
      applyStimulus(1'b0, pI, wI, aI, dI, pD, wD, aD, dD, accI, accD);
      if (accI) pI = 1'b0;
      if (accD) pD = 1'b0;
      nextCycle();
    end
    for (int k = 0; k < 6; k++) begin
      idleCycle();
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
